// File: rtl/hedios_controller_gen2.sv
// Hedios command decoder/scheduler: pops RX packets, triggers actions, and
// answers through the TX FIFO with slot readback, status and error replies.
//  state  | meaning
//  IDLE   | wait for lost-data report or an RX packet (pop issued here)
//  POP    | FIFO read latency cycle
//  DECODE | sample head packet, trigger actions, load reply or range
//  SEND   | hold reply until TX has room, then push once
//  STREAM | push next slot of the active range, stall on tx_full
//  GAP    | spacer so stream pushes are never back-to-back
module hedios_controller_gen2 #(
  parameter int SLOT_COUNT           = 4,
  parameter int VAR_ACTION_COUNT     = 2,
  parameter int VARLESS_ACTION_COUNT = 2,
  parameter int DATA_W               = 32,
  parameter int ACK_ACTIONS          = 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               rx_empty,
  input  logic                               rx_lost_data,
  input  logic [7:0]                         rx_command,
  input  logic [DATA_W-1:0]                  rx_data,
  output logic                               rx_pop_packet,
  input  logic                               tx_full,
  output logic [7:0]                         tx_command,
  output logic [DATA_W-1:0]                  tx_data,
  output logic                               tx_push_packet,
  input  logic [SLOT_COUNT*DATA_W-1:0]       slots,
  output logic [VAR_ACTION_COUNT-1:0]        var_actions,
  output logic [VAR_ACTION_COUNT*DATA_W-1:0] var_action_parameter,
  output logic [VARLESS_ACTION_COUNT-1:0]    varless_actions,
  output logic                               rst_device,
  output logic                               busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_POP, S_DECODE, S_SEND, S_STREAM, S_GAP
  } state_t;

  state_t state_q, state_d;
  logic lost_q, lost_d;
  logic pop_q, pop_d;
  logic push_q, push_d;
  logic rst_dev_q, rst_dev_d;
  logic [7:0] tx_cmd_q, tx_cmd_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic [VAR_ACTION_COUNT-1:0] var_act_q, var_act_d;
  logic [VARLESS_ACTION_COUNT-1:0] varless_act_q, varless_act_d;
  logic [VAR_ACTION_COUNT*DATA_W-1:0] param_q, param_d;
  logic [8:0] ctr_q, ctr_d;
  logic [8:0] end_q, end_d;

  logic [5:0] act_id;
  logic act_var;
  logic act_valid;
  logic [7:0] rng_start;
  logic [7:0] rng_count;
  logic [8:0] rng_end;
  logic [8:0] slot_sel;
  logic slot_id_ok;
  logic [DATA_W-1:0] slot_val;

  assign act_id    = rx_command[5:0];
  assign act_var   = rx_command[6];
  assign act_valid = act_var ? ({1'b0, act_id} < 7'(VAR_ACTION_COUNT))
                             : ({1'b0, act_id} < 7'(VARLESS_ACTION_COUNT));
  assign rng_start = rx_data[7:0];
  assign rng_count = rx_data[15:8];
  assign rng_end   = {1'b0, rng_start} + {1'b0, rng_count};
  assign slot_id_ok = {1'b0, rx_data[7:0]} < 9'(SLOT_COUNT);

  // One slot mux serves both single-slot replies (DECODE) and streaming.
  assign slot_sel = (state_q == S_DECODE) ? {1'b0, rx_data[7:0]} : ctr_q;

  always_comb begin
    slot_val = '0;
    for (int i = 0; i < SLOT_COUNT; i++) begin
      if (slot_sel == 9'(i)) slot_val = slots[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    state_d       = state_q;
    lost_d        = lost_q | rx_lost_data;
    pop_d         = 1'b0;
    push_d        = 1'b0;
    rst_dev_d     = 1'b0;
    tx_cmd_d      = tx_cmd_q;
    tx_data_d     = tx_data_q;
    var_act_d     = '0;
    varless_act_d = '0;
    param_d       = param_q;
    ctr_d         = ctr_q;
    end_d         = end_q;

    case (state_q)
      S_IDLE: begin
        if (lost_q) begin
          tx_cmd_d  = 8'h08;
          tx_data_d = DATA_W'(1);
          lost_d    = rx_lost_data;
          state_d   = S_SEND;
        end else if (!rx_empty) begin
          pop_d   = 1'b1;
          state_d = S_POP;
        end
      end

      S_POP: state_d = S_DECODE;

      S_DECODE: begin
        state_d = S_SEND;
        if (rx_command[7]) begin
          if (!act_valid) begin
            tx_cmd_d  = 8'h0a;
            tx_data_d = DATA_W'(act_id);
          end else begin
            for (int i = 0; i < VAR_ACTION_COUNT; i++) begin
              if (act_var && act_id == 6'(i)) begin
                var_act_d[i]                = 1'b1;
                param_d[i*DATA_W +: DATA_W] = rx_data;
              end
            end
            for (int i = 0; i < VARLESS_ACTION_COUNT; i++) begin
              if (!act_var && act_id == 6'(i)) varless_act_d[i] = 1'b1;
            end
            if (ACK_ACTIONS != 0) begin
              tx_cmd_d  = 8'h02;
              tx_data_d = DATA_W'(act_id);
            end else begin
              state_d = S_IDLE;
            end
          end
        end else begin
          case (rx_command)
            8'h01: begin
              tx_cmd_d  = 8'h03;
              tx_data_d = '0;
            end
            8'h02: begin
              if (slot_id_ok) begin
                tx_cmd_d  = {1'b1, rx_data[6:0]};
                tx_data_d = slot_val;
              end else begin
                tx_cmd_d  = 8'h09;
                tx_data_d = DATA_W'(rx_data[7:0]);
              end
            end
            8'h03: begin
              ctr_d   = '0;
              end_d   = 9'(SLOT_COUNT);
              state_d = S_STREAM;
            end
            8'h06: begin
              if (rng_count == 8'd0 || rng_end > 9'(SLOT_COUNT)) begin
                tx_cmd_d  = 8'h09;
                tx_data_d = DATA_W'(rng_start);
              end else begin
                ctr_d   = {1'b0, rng_start};
                end_d   = rng_end;
                state_d = S_STREAM;
              end
            end
            8'h04: begin
              tx_cmd_d  = 8'h05;
              tx_data_d = DATA_W'(SLOT_COUNT);
            end
            8'h05: begin
              tx_cmd_d  = 8'h06;
              tx_data_d = DATA_W'({8'(VARLESS_ACTION_COUNT), 8'(VAR_ACTION_COUNT)});
            end
            8'h55: begin
              rst_dev_d = 1'b1;
              state_d   = S_IDLE;
            end
            default: begin
              tx_cmd_d  = 8'h0b;
              tx_data_d = '0;
            end
          endcase
        end
      end

      S_SEND: begin
        if (!tx_full) begin
          push_d  = 1'b1;
          state_d = S_IDLE;
        end
      end

      S_STREAM: begin
        if (ctr_q < end_q) begin
          if (!tx_full) begin
            push_d    = 1'b1;
            tx_cmd_d  = {1'b1, ctr_q[6:0]};
            tx_data_d = slot_val;
            ctr_d     = ctr_q + 9'd1;
            state_d   = S_GAP;
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      S_GAP: state_d = S_STREAM;

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      lost_q        <= 1'b0;
      pop_q         <= 1'b0;
      push_q        <= 1'b0;
      rst_dev_q     <= 1'b0;
      tx_cmd_q      <= '0;
      tx_data_q     <= '0;
      var_act_q     <= '0;
      varless_act_q <= '0;
      param_q       <= '0;
      ctr_q         <= '0;
      end_q         <= '0;
    end else begin
      state_q       <= state_d;
      lost_q        <= lost_d;
      pop_q         <= pop_d;
      push_q        <= push_d;
      rst_dev_q     <= rst_dev_d;
      tx_cmd_q      <= tx_cmd_d;
      tx_data_q     <= tx_data_d;
      var_act_q     <= var_act_d;
      varless_act_q <= varless_act_d;
      param_q       <= param_d;
      ctr_q         <= ctr_d;
      end_q         <= end_d;
    end
  end

  assign rx_pop_packet        = pop_q;
  assign tx_push_packet       = push_q;
  assign tx_command           = tx_cmd_q;
  assign tx_data              = tx_data_q;
  assign var_actions          = var_act_q;
  assign varless_actions      = varless_act_q;
  assign var_action_parameter = param_q;
  assign rst_device           = rst_dev_q;
  assign busy                 = (state_q != S_IDLE);

endmodule

// File: tb/tb_hedios_controller_gen2.sv
// Directed bench for hedios_controller_gen2 (default parameters): a negedge
// monitor logs pushes/pops/pulses, the main sequence checks them with assertions.
module tb_hedios_controller_gen2;

  localparam logic [31:0] S0 = 32'hA0A0_0000;
  localparam logic [31:0] S1 = 32'hB1B1_1111;
  localparam logic [31:0] S2 = 32'hC2C2_2222;
  localparam logic [31:0] S3 = 32'hD3D3_3333;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         rx_empty = 1'b1;
  logic         rx_lost_data = 1'b0;
  logic [7:0]   rx_command = 8'h00;
  logic [31:0]  rx_data = 32'h0;
  logic         rx_pop_packet;
  logic         tx_full = 1'b0;
  logic [7:0]   tx_command;
  logic [31:0]  tx_data;
  logic         tx_push_packet;
  logic [127:0] slots;
  logic [1:0]   var_actions;
  logic [63:0]  var_action_parameter;
  logic [1:0]   varless_actions;
  logic         rst_device;
  logic         busy;

  assign slots = {S3, S2, S1, S0};

  hedios_controller_gen2 dut (
    .clk(clk), .rst(rst), .rx_empty(rx_empty), .rx_lost_data(rx_lost_data),
    .rx_command(rx_command), .rx_data(rx_data), .rx_pop_packet(rx_pop_packet),
    .tx_full(tx_full), .tx_command(tx_command), .tx_data(tx_data),
    .tx_push_packet(tx_push_packet), .slots(slots), .var_actions(var_actions),
    .var_action_parameter(var_action_parameter), .varless_actions(varless_actions),
    .rst_device(rst_device), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  logic [7:0]  push_cmd_q[$];
  logic [31:0] push_data_q[$];
  int          push_cyc_q[$];
  int          pop_cyc_q[$];
  int consec_push = 0, consec_pop = 0, full_viol = 0;
  int var_cnt0 = 0, var_cnt1 = 0, vl_cnt0 = 0, vl_cnt1 = 0, rstdev_cnt = 0;
  logic prev_push = 1'b0, prev_pop = 1'b0, full_prev = 1'b0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (tx_push_packet) begin
      push_cmd_q.push_back(tx_command);
      push_data_q.push_back(tx_data);
      push_cyc_q.push_back(cyc);
      if (prev_push) consec_push++;
      if (full_prev) full_viol++;
    end
    if (rx_pop_packet) begin
      pop_cyc_q.push_back(cyc);
      if (prev_pop) consec_pop++;
    end
    if (var_actions[0]) var_cnt0++;
    if (var_actions[1]) var_cnt1++;
    if (varless_actions[0]) vl_cnt0++;
    if (varless_actions[1]) vl_cnt1++;
    if (rst_device) rstdev_cnt++;
    prev_push = tx_push_packet;
    prev_pop  = rx_pop_packet;
    full_prev = tx_full;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    push_cmd_q.delete();
    push_data_q.delete();
    push_cyc_q.delete();
    pop_cyc_q.delete();
  endtask

  task automatic send_pkt(input string tag, input logic [7:0] cmd, input logic [31:0] data);
    int n;
    int b;
    n = pop_cyc_q.size();
    b = 0;
    rx_command = cmd;
    rx_data    = data;
    rx_empty   = 1'b0;
    while (pop_cyc_q.size() == n && b < 100) begin
      tick();
      b++;
    end
    rx_empty = 1'b1;
    if (pop_cyc_q.size() == n) chk({tag, "_pop_timeout"}, 64'(0), 64'(1));
  endtask

  task automatic wait_pushes(input int n);
    int b;
    b = 0;
    while (push_cmd_q.size() < n && b < 200) begin
      tick();
      b++;
    end
  endtask

  task automatic wait_idle();
    int b;
    b = 0;
    while (busy && b < 200) begin
      tick();
      b++;
    end
    repeat (3) tick();
  endtask

  task automatic do_single(input string tag, input logic [7:0] cmd, input logic [31:0] data,
                           input logic [7:0] exp_cmd, input logic [31:0] exp_data);
    clear_log();
    send_pkt(tag, cmd, data);
    wait_pushes(1);
    wait_idle();
    chk({tag, "_npush"}, 64'(push_cmd_q.size()), 64'(1));
    if (push_cmd_q.size() > 0) begin
      chk({tag, "_cmd"}, 64'(push_cmd_q[0]), 64'(exp_cmd));
      chk({tag, "_data"}, 64'(push_data_q[0]), 64'(exp_data));
    end
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_pulses", 64'({rx_pop_packet, tx_push_packet, var_actions, varless_actions, rst_device, busy}), 64'(0));
    chk("rst_tx", 64'({tx_command, tx_data}), 64'(0));
    chk("rst_param", var_action_parameter, 64'(0));
    rst = 1'b0;
    repeat (2) tick();

    // 1. PING latency and busy release
    clear_log();
    send_pkt("ping", 8'h01, 32'h0);
    wait_pushes(1);
    chk("ping_cmd", 64'(push_cmd_q[0]), 64'h03);
    chk("ping_data", 64'(push_data_q[0]), 64'h0);
    chk("ping_latency", 64'(push_cyc_q[0] - pop_cyc_q[0]), 64'(3));
    chk("ping_busy", 64'(busy), 64'(0));
    wait_idle();

    // 2. ranges
    clear_log();
    send_pkt("rng12", 8'h06, 32'h0000_0201);
    wait_pushes(2);
    wait_idle();
    chk("rng12_n", 64'(push_cmd_q.size()), 64'(2));
    chk("rng12_c0", 64'(push_cmd_q[0]), 64'h81);
    chk("rng12_d0", 64'(push_data_q[0]), 64'(S1));
    chk("rng12_c1", 64'(push_cmd_q[1]), 64'h82);
    chk("rng12_d1", 64'(push_data_q[1]), 64'(S2));
    chk("rng12_gap", 64'(push_cyc_q[1] - push_cyc_q[0] >= 2), 64'(1));
    do_single("rng32", 8'h06, 32'h0000_0203, 8'h09, 32'd3);
    do_single("rng_cnt0", 8'h06, 32'h0000_0002, 8'h09, 32'd2);
    do_single("slot3", 8'h02, 32'h0000_0003, 8'h83, S3);
    do_single("slot4", 8'h02, 32'h0000_0004, 8'h09, 32'd4);

    // 3. actions and misc commands
    do_single("var1", 8'hC1, 32'hDEAD_BEEF, 8'h02, 32'd1);
    chk("var1_pulse1", 64'(var_cnt1), 64'(1));
    chk("var1_pulse0", 64'(var_cnt0), 64'(0));
    chk("var1_param", var_action_parameter, 64'hDEAD_BEEF_0000_0000);
    do_single("var5", 8'hC5, 32'h1234_5678, 8'h0a, 32'd5);
    chk("var5_nopulse", 64'(var_cnt0 + var_cnt1), 64'(1));
    chk("var5_param", var_action_parameter, 64'hDEAD_BEEF_0000_0000);
    do_single("vl0", 8'h80, 32'h0, 8'h02, 32'd0);
    chk("vl0_pulse", 64'({vl_cnt1[7:0], vl_cnt0[7:0]}), 64'h0001);
    do_single("vl2", 8'h82, 32'h0, 8'h0a, 32'd2);
    chk("vl2_nopulse", 64'(vl_cnt0 + vl_cnt1), 64'(1));
    do_single("slotcnt", 8'h04, 32'h0, 8'h05, 32'd4);
    do_single("actcnt", 8'h05, 32'h0, 8'h06, 32'h0000_0202);
    do_single("unknown", 8'h77, 32'hFFFF_FFFF, 8'h0b, 32'd0);
    clear_log();
    send_pkt("rstdev", 8'h55, 32'h0);
    wait_idle();
    chk("rstdev_pulse", 64'(rstdev_cnt), 64'(1));
    chk("rstdev_nopush", 64'(push_cmd_q.size()), 64'(0));

    // 4. backpressure during UPDATE_ALL
    clear_log();
    tx_full = 1'b1;
    send_pkt("full", 8'h03, 32'h0);
    repeat (10) tick();
    chk("full_nopush", 64'(push_cmd_q.size()), 64'(0));
    tx_full = 1'b0;
    wait_pushes(4);
    wait_idle();
    chk("full_n", 64'(push_cmd_q.size()), 64'(4));
    chk("full_c", 64'({push_cmd_q[0], push_cmd_q[1], push_cmd_q[2], push_cmd_q[3]}), 64'h8081_8283);
    chk("full_d01", 64'({push_data_q[0], push_data_q[1]}), {S0, S1});
    chk("full_d23", 64'({push_data_q[2], push_data_q[3]}), {S2, S3});
    chk("full_viol", 64'(full_viol), 64'(0));

    // 5. lost data during a stream, PING queued behind it
    clear_log();
    send_pkt("lost", 8'h03, 32'h0);
    tick(); rx_lost_data = 1'b1;
    tick(); rx_lost_data = 1'b0;
    tick(); rx_lost_data = 1'b1;
    tick(); rx_lost_data = 1'b0;
    rx_command = 8'h01;
    rx_data    = 32'h0;
    rx_empty   = 1'b0;
    for (int b = 0; b < 100 && pop_cyc_q.size() < 2; b++) tick();
    rx_empty = 1'b1;
    wait_pushes(6);
    wait_idle();
    chk("lost_n", 64'(push_cmd_q.size()), 64'(6));
    chk("lost_err", 64'({push_cmd_q[4], push_data_q[4]}), 64'h08_0000_0001);
    chk("lost_pong", 64'({push_cmd_q[5], push_data_q[5]}), 64'h03_0000_0000);
    chk("lost_before_pop", 64'(push_cyc_q[4] < pop_cyc_q[1]), 64'(1));

    // 6. reset mid-stream clears the flag and aborts the range
    clear_log();
    send_pkt("midrst", 8'h03, 32'h0);
    tick(); rx_lost_data = 1'b1;
    tick(); rx_lost_data = 1'b0;
    tick(); rst = 1'b1;
    tick();
    chk("midrst_pulses", 64'({rx_pop_packet, tx_push_packet, var_actions, varless_actions, rst_device, busy}), 64'(0));
    chk("midrst_tx", 64'({tx_command, tx_data}), 64'(0));
    chk("midrst_param", var_action_parameter, 64'(0));
    rst = 1'b0;
    repeat (6) tick();
    chk("midrst_npush", 64'(push_cmd_q.size()), 64'(1));
    chk("midrst_first", 64'({push_cmd_q[0], push_data_q[0]}), {32'h80, S0});
    do_single("post_ping", 8'h01, 32'h0, 8'h03, 32'd0);

    chk("no_consec_push", 64'(consec_push), 64'(0));
    chk("no_consec_pop", 64'(consec_pop), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
